// File: rtl/seg7_bus_arbiter.sv
// Round-robin arbiter sharing the 7-segment display bus between two requesters.
// Every grant becomes one single-cycle bus write, followed by a programmable hold-off.
module seg7_bus_arbiter #(
  parameter logic [7:0]  BASE_ADDR   = 8'hD0,
  parameter logic [7:0]  DOT_ADDR    = 8'hD1,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0,
  input  logic       REQ0_DOT,
  input  logic [7:0] REQ0_DATA,
  output logic       ACK0,
  input  logic       REQ1,
  input  logic       REQ1_DOT,
  input  logic [7:0] REQ1_DATA,
  output logic       ACK1,
  output logic [7:0] BUS_ADDR,
  output logic [7:0] BUS_DATA,
  output logic       BUS_WE,
  output logic       BUSY
);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  localparam logic [CNT_WIDTH-1:0] HOLD_VAL = CNT_WIDTH'(HOLD_CYCLES);

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 last_served, last_next;
  logic                 winner;
  logic                 we_next, ack0_next, ack1_next, busy_next;
  logic [7:0]           addr_next, data_next;

  // On a tie the requester that was not served last wins.
  always_comb begin
    winner = (REQ0 && REQ1) ? ~last_served : REQ1;
  end

  // Every output is computed one cycle ahead and registered below.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    last_next  = last_served;
    we_next    = 1'b0;
    ack0_next  = 1'b0;
    ack1_next  = 1'b0;
    busy_next  = 1'b0;
    addr_next  = 8'h00;
    data_next  = 8'h00;
    case (state)
      IDLE: begin
        if (REQ0 || REQ1) begin
          state_next = WRITE;
          last_next  = winner;
          we_next    = 1'b1;
          ack0_next  = ~winner;
          ack1_next  = winner;
          busy_next  = 1'b1;
          addr_next  = (winner ? REQ1_DOT : REQ0_DOT) ? DOT_ADDR : BASE_ADDR;
          data_next  = winner ? REQ1_DATA : REQ0_DATA;
        end
      end
      WRITE: begin
        if (HOLD_CYCLES > 0) begin
          state_next = HOLD;
          busy_next  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        cnt_next = cnt + 1'b1;
        if (cnt_next == HOLD_VAL) begin
          state_next = IDLE;
        end else begin
          busy_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      last_served <= 1'b1;
      BUS_WE      <= 1'b0;
      ACK0        <= 1'b0;
      ACK1        <= 1'b0;
      BUSY        <= 1'b0;
      BUS_ADDR    <= 8'h00;
      BUS_DATA    <= 8'h00;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      last_served <= last_next;
      BUS_WE      <= we_next;
      ACK0        <= ack0_next;
      ACK1        <= ack1_next;
      BUSY        <= busy_next;
      BUS_ADDR    <= addr_next;
      BUS_DATA    <= data_next;
    end
  end

endmodule
